// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - response codes and FSM state type for the AXI-lite master bridge
package axi_lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WRESP,
    ST_RADDR,
    ST_RDATA
  } bridge_state_e;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return axi_resp_e'(resp) != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_lite_master_bridge_if.sv
// rtl/axi_lite_master_bridge_if.sv - AXI-lite bus between the bridge (master) and a slave
interface axi_lite_master_bridge_if;
  logic [31:0] m_awaddr;
  logic        m_awvalid;
  logic        m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid;
  logic        m_wready;
  logic [1:0]  m_bresp;
  logic        m_bvalid;
  logic        m_bready;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid;
  logic        m_rready;

  modport master (
    output m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
           m_araddr, m_arvalid, m_rready,
    input  m_awready, m_wready, m_bresp, m_bvalid, m_arready,
           m_rdata, m_rresp, m_rvalid
  );

  modport slave (
    input  m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
           m_araddr, m_arvalid, m_rready,
    output m_awready, m_wready, m_bresp, m_bvalid, m_arready,
           m_rdata, m_rresp, m_rvalid
  );
endinterface

// File: rtl/axi_lite_master_bridge.sv
// rtl/axi_lite_master_bridge.sv - single-outstanding core request to AXI-lite master bridge
// with a per-transaction timeout that forces an error completion.
module axi_lite_master_bridge
  import axi_lite_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  axi_lite_master_bridge_if.master m
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  bridge_state_e state_q, state_d;
  logic [31:0]   addr_q, wdata_q;
  logic [3:0]    be_q;
  logic          awvalid_q, awvalid_d;
  logic          wvalid_q, wvalid_d;
  logic          arvalid_q, arvalid_d;
  logic          bready_q, bready_d;
  logic          rready_q, rready_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          done_d, err_d, capture;
  logic [31:0]   rdata_d;

  assign gnt_o = req_i && (state_q == ST_IDLE);

  // Direction is carried by the state; only the payload needs capturing.
  assign m.m_awaddr  = addr_q;
  assign m.m_araddr  = addr_q;
  assign m.m_wdata   = wdata_q;
  assign m.m_wstrb   = be_q;
  assign m.m_awvalid = awvalid_q;
  assign m.m_wvalid  = wvalid_q;
  assign m.m_arvalid = arvalid_q;
  assign m.m_bready  = bready_q;
  assign m.m_rready  = rready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      timer_q   <= '0;
      rvalid_o  <= 1'b0;
      err_o     <= 1'b0;
      rdata_o   <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      bready_q  <= bready_d;
      rready_q  <= rready_d;
      timer_q   <= timer_d;
      rvalid_o  <= done_d;
      err_o     <= err_d;
      rdata_o   <= rdata_d;
      if (capture) begin
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        be_q    <= be_i;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    timer_d   = timer_q;
    capture   = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    rdata_d   = '0;

    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          capture = 1'b1;
          timer_d = '0;
          if (we_i) begin
            state_d   = ST_WRITE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = ST_RADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        // AW and W complete independently; move on once both are gone.
        if (awvalid_q && m.m_awready) awvalid_d = 1'b0;
        if (wvalid_q && m.m_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d)  state_d   = ST_WRESP;
      end
      ST_WRESP: begin
        if (m.m_bvalid) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          err_d   = resp_is_err(m.m_bresp);
        end
      end
      ST_RADDR: begin
        if (m.m_arready) begin
          arvalid_d = 1'b0;
          state_d   = ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (m.m_rvalid) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          err_d   = resp_is_err(m.m_rresp);
          rdata_d = err_d ? 32'h0 : m.m_rdata;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE) begin
      timer_d = timer_q + TW'(1);
      // A response arriving on the last allowed cycle still wins over the timeout.
      if ((timer_q == TW'(TIMEOUT_CYCLES - 1)) && !done_d) begin
        state_d   = ST_IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        arvalid_d = 1'b0;
        done_d    = 1'b1;
        err_d     = 1'b1;
        rdata_d   = '0;
      end
    end

    // Ready in IDLE so late responses from an abandoned transaction drain silently.
    bready_d = (state_d == ST_IDLE) || (state_d == ST_WRESP);
    rready_d = (state_d == ST_IDLE) || (state_d == ST_RDATA);
  end

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// tb/tb_axi_lite_master_bridge.sv - bench for axi_lite_master_bridge: register-slave model,
// per-cycle completion checker and directed transactions.
module tb_axi_lite_master_bridge;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i = 1'b0;
  logic        gnt_o;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [3:0]  be_i = '0;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  axi_lite_master_bridge_if bus ();

  axi_lite_master_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req_i),
    .gnt_o    (gnt_o),
    .we_i     (we_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .be_i     (be_i),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o),
    .err_o    (err_o),
    .m        (bus)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Slave configuration, set by the stimulus process.
  int          aw_lat = 0, w_lat = 0, ar_lat = 0;
  bit          ar_never = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  bit          b_req = 0;

  // Slave and reference-model state.
  logic [31:0] mem [0:15];
  int          cyc = 0, grant_cyc = 0, exp_cyc = 0;
  bit          outstanding = 0, resp_seen = 0, exp_pend = 0;
  logic [31:0] exp_rdata = '0;
  logic        exp_err = 1'b0;
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
  bit          aw_got = 0, w_got = 0, r_req = 0, b_fired = 0, r_fired = 0;
  logic [31:0] aw_addr_s = '0, w_data_s = '0, r_data_s = '0;
  logic [3:0]  w_strb_s = '0, last_wstrb = '0;
  int          aw_hs = 0, w_hs = 0, b_hs = 0;
  bit          aw_wait = 0, w_wait = 0, ar_wait = 0;
  logic [31:0] aw_wait_addr = '0, w_wait_data = '0, ar_wait_addr = '0;
  bit          due_resp, due_to;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    bus.m_awready = 1'b0; bus.m_wready = 1'b0; bus.m_arready = 1'b0;
    bus.m_bvalid = 1'b0;  bus.m_bresp = 2'b00;
    bus.m_rvalid = 1'b0;  bus.m_rresp = 2'b00; bus.m_rdata = '0;
    forever begin
      @(negedge clk);
      #3;
      cyc++;
      if (!rst_n) begin
        outstanding = 0; resp_seen = 0; exp_pend = 0;
        aw_got = 0; w_got = 0; r_req = 0; b_fired = 0; r_fired = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0;
        bus.m_awready = 1'b0; bus.m_wready = 1'b0; bus.m_arready = 1'b0;
        bus.m_bvalid = 1'b0; bus.m_rvalid = 1'b0;
        continue;
      end

      // Completion expected now: one cycle after the response beat, or TO+1 after grant.
      due_resp = exp_pend && (exp_cyc == cyc);
      due_to   = outstanding && !resp_seen && (cyc == grant_cyc + TO + 1);
      chk("rvalid_o", {31'h0, rvalid_o}, {31'h0, due_resp || due_to});
      if (due_resp || due_to) begin
        chk("rdata_o", rdata_o, due_resp ? exp_rdata : 32'h0);
        chk("err_o", {31'h0, err_o}, {31'h0, due_resp ? exp_err : 1'b1});
        outstanding = 0;
        exp_pend = 0;
      end
      if (gnt_o) begin
        outstanding = 1; resp_seen = 0; grant_cyc = cyc;
      end

      // A valid left waiting must still be up with the same payload.
      if (!rvalid_o) begin
        if (aw_wait) begin
          chk("awvalid_hold", {31'h0, bus.m_awvalid}, 32'h1);
          chk("awaddr_hold", bus.m_awaddr, aw_wait_addr);
        end
        if (w_wait) begin
          chk("wvalid_hold", {31'h0, bus.m_wvalid}, 32'h1);
          chk("wdata_hold", bus.m_wdata, w_wait_data);
        end
        if (ar_wait) begin
          chk("arvalid_hold", {31'h0, bus.m_arvalid}, 32'h1);
          chk("araddr_hold", bus.m_araddr, ar_wait_addr);
        end
      end

      if (b_fired) bus.m_bvalid = 1'b0;
      if (r_fired) bus.m_rvalid = 1'b0;
      b_fired = 0; r_fired = 0;
      if (b_req) begin
        bus.m_bvalid = 1'b1; bus.m_bresp = bresp_cfg; b_req = 0;
      end
      if (r_req) begin
        bus.m_rvalid = 1'b1; bus.m_rdata = r_data_s; bus.m_rresp = rresp_cfg; r_req = 0;
      end

      bus.m_awready = bus.m_awvalid && !aw_got && (aw_cnt >= aw_lat);
      bus.m_wready  = bus.m_wvalid && !w_got && (w_cnt >= w_lat);
      bus.m_arready = bus.m_arvalid && !ar_never && (ar_cnt >= ar_lat);

      if (bus.m_awvalid && bus.m_awready) begin
        aw_got = 1; aw_addr_s = bus.m_awaddr; aw_cnt = 0; aw_hs++;
      end else if (bus.m_awvalid) aw_cnt++;
      if (bus.m_wvalid && bus.m_wready) begin
        w_got = 1; w_data_s = bus.m_wdata; w_strb_s = bus.m_wstrb; last_wstrb = bus.m_wstrb;
        w_cnt = 0; w_hs++;
      end else if (bus.m_wvalid) w_cnt++;
      if (aw_got && w_got) begin
        if (bresp_cfg == 2'b00)
          for (int b = 0; b < 4; b++)
            if (w_strb_s[b]) mem[aw_addr_s[5:2]][8*b +: 8] = w_data_s[8*b +: 8];
        aw_got = 0; w_got = 0; b_req = 1;
      end
      if (bus.m_arvalid && bus.m_arready) begin
        r_req = 1; r_data_s = mem[bus.m_araddr[5:2]]; ar_cnt = 0;
      end else if (bus.m_arvalid) ar_cnt++;

      if (bus.m_bvalid && bus.m_bready) begin
        b_fired = 1; b_hs++;
        if (outstanding && !resp_seen) begin
          resp_seen = 1; exp_pend = 1; exp_cyc = cyc + 1;
          exp_rdata = '0; exp_err = (bus.m_bresp != 2'b00);
        end
      end
      if (bus.m_rvalid && bus.m_rready) begin
        r_fired = 1;
        if (outstanding && !resp_seen) begin
          resp_seen = 1; exp_pend = 1; exp_cyc = cyc + 1;
          exp_err = (bus.m_rresp != 2'b00);
          exp_rdata = exp_err ? 32'h0 : bus.m_rdata;
        end
      end

      aw_wait = bus.m_awvalid && !bus.m_awready; aw_wait_addr = bus.m_awaddr;
      w_wait  = bus.m_wvalid && !bus.m_wready;   w_wait_data  = bus.m_wdata;
      ar_wait = bus.m_arvalid && !bus.m_arready; ar_wait_addr = bus.m_araddr;
    end
  end

  // Called just after a negedge; returns just after the negedge of the completion cycle.
  task automatic do_txn(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, output logic [31:0] rd, output logic er,
                        output int lat);
    int n;
    req_i = 1'b1; we_i = we; addr_i = a; wdata_i = d; be_i = be;
    #1;
    n = 0;
    while (!gnt_o && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("gnt_o", {31'h0, gnt_o}, 32'h1);
    lat = 0;
    do begin
      @(negedge clk); req_i = 1'b0; #1; lat++;
    end while (!rvalid_o && lat < 60);
    chk("completion_seen", {31'h0, rvalid_o}, 32'h1);
    rd = rdata_o; er = err_o;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, aw0, w0, b0;

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion within 20000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rvalid_o", {31'h0, rvalid_o}, 32'h0);
    chk("rst_err_o", {31'h0, err_o}, 32'h0);
    chk("rst_rdata_o", rdata_o, 32'h0);
    chk("rst_valids", {29'h0, bus.m_awvalid, bus.m_wvalid, bus.m_arvalid}, 32'h0);
    chk("rst_readies", {30'h0, bus.m_bready, bus.m_rready}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    chk("idle_readies", {30'h0, bus.m_bready, bus.m_rready}, 32'h3);

    // Zero-wait write then reads.
    aw0 = aw_hs; w0 = w_hs;
    do_txn(1'b1, 32'h4, 32'hDEADBEEF, 4'hF, rd, er, lat);
    chk("wr4_err", {31'h0, er}, 32'h0);
    chk("wr4_rdata", rd, 32'h0);
    chk("wr4_lat", lat, 3);
    chk("wr4_aw_hs", aw_hs - aw0, 1);
    chk("wr4_w_hs", w_hs - w0, 1);
    do_txn(1'b0, 32'h4, 32'h0, 4'h0, rd, er, lat);
    chk("rd4_data", rd, 32'hDEADBEEF);
    chk("rd4_err", {31'h0, er}, 32'h0);
    chk("rd4_lat", lat, 3);
    do_txn(1'b0, 32'hC, 32'h0, 4'h0, rd, er, lat);
    chk("rdC_data", rd, 32'h0);

    // Strobes: none, then bytes 0 and 2.
    do_txn(1'b1, 32'h8, 32'h12345678, 4'h0, rd, er, lat);
    chk("wr8_wstrb", {28'h0, last_wstrb}, 32'h0);
    chk("wr8_err", {31'h0, er}, 32'h0);
    do_txn(1'b0, 32'h8, 32'h0, 4'h0, rd, er, lat);
    chk("rd8_data", rd, 32'h0);
    do_txn(1'b1, 32'h10, 32'hAABBCCDD, 4'h5, rd, er, lat);
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("rd10_data", rd, 32'h00BB00DD);

    // W accepted 3 cycles ahead of AW, then the reverse.
    w_lat = 0; aw_lat = 3;
    do_txn(1'b1, 32'h14, 32'h11111111, 4'hF, rd, er, lat);
    chk("wr14_lat", lat, 6);
    aw_lat = 0; w_lat = 3;
    do_txn(1'b1, 32'h18, 32'h22222222, 4'hF, rd, er, lat);
    chk("wr18_lat", lat, 6);
    aw_lat = 0; w_lat = 0;
    do_txn(1'b0, 32'h14, 32'h0, 4'h0, rd, er, lat);
    chk("rd14_data", rd, 32'h11111111);
    do_txn(1'b0, 32'h18, 32'h0, 4'h0, rd, er, lat);
    chk("rd18_data", rd, 32'h22222222);

    // Error responses.
    rresp_cfg = 2'b10;
    do_txn(1'b0, 32'h4, 32'h0, 4'h0, rd, er, lat);
    chk("rd_slverr_err", {31'h0, er}, 32'h1);
    chk("rd_slverr_data", rd, 32'h0);
    rresp_cfg = 2'b00; bresp_cfg = 2'b11;
    do_txn(1'b1, 32'h1C, 32'h55555555, 4'hF, rd, er, lat);
    chk("wr_decerr_err", {31'h0, er}, 32'h1);
    bresp_cfg = 2'b00;

    // Stray write response while idle is consumed with no completion.
    b0 = b_hs;
    b_req = 1;
    repeat (4) @(negedge clk);
    #1;
    chk("stray_b_consumed", b_hs - b0, 1);

    // Read address never accepted: forced error completion.
    ar_never = 1;
    do_txn(1'b0, 32'h4, 32'h0, 4'h0, rd, er, lat);
    chk("to_lat", lat, TO + 1);
    chk("to_err", {31'h0, er}, 32'h1);
    chk("to_rdata", rd, 32'h0);
    chk("to_arvalid_0", {31'h0, bus.m_arvalid}, 32'h0);
    @(negedge clk); #1;
    chk("to_arvalid_1", {31'h0, bus.m_arvalid}, 32'h0);
    ar_never = 0;

    // Reset while the write address is still waiting.
    aw_lat = 1000; w_lat = 1000;
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h4; wdata_i = 32'hCAFEF00D; be_i = 4'hF;
    #1;
    chk("rst_txn_gnt", {31'h0, gnt_o}, 32'h1);
    @(negedge clk); req_i = 1'b0; #1;
    chk("rst_txn_awvalid", {31'h0, bus.m_awvalid}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valids", {29'h0, bus.m_awvalid, bus.m_wvalid, bus.m_arvalid}, 32'h0);
    chk("midrst_readies", {30'h0, bus.m_bready, bus.m_rready}, 32'h0);
    chk("midrst_rvalid", {31'h0, rvalid_o}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; aw_lat = 0; w_lat = 0;
    @(negedge clk); #1;
    do_txn(1'b0, 32'h4, 32'h0, 4'h0, rd, er, lat);
    chk("postrst_rd4", rd, 32'hDEADBEEF);
    chk("postrst_err", {31'h0, er}, 32'h0);

    // Back-to-back: the next request is granted in the completion cycle.
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("b2b_rd10", rd, 32'h00BB00DD);
    do_txn(1'b0, 32'h14, 32'h0, 4'h0, rd, er, lat);
    chk("b2b_rd14", rd, 32'h11111111);
    chk("b2b_lat", lat, 3);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
